// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, qualifies the synchronized lock over a stable
// window, releases system reset only in RUN, retries on timeout, then latches a fault.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 4,
  parameter int RETRY_W             = 3
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               retry_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               pll_ok,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [7:0]         lol_count
);

  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [PW-1:0]      PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0]      TO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0]      STAB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, QUALIFY, RUN, FAULT} state_t;

  state_t        state, nxt;
  logic [1:0]    sync_pipe;
  logic          lock_s;
  logic [PW-1:0] pulse_cnt;
  logic [TW-1:0] to_cnt;
  logic [SW-1:0] stab_cnt;
  logic          timeout, stab_done, timed_out, retry_inc, retry_clr, lol_hit;

  assign lock_s = sync_pipe[1];

  // Timeout and stable-complete are "would reach the limit on this edge" so the
  // state change lands exactly on the limit cycle.
  always_comb begin
    nxt       = state;
    timeout   = (to_cnt == TO_LAST);
    stab_done = lock_s && (stab_cnt == STAB_LAST);
    timed_out = 1'b0;
    retry_clr = 1'b0;
    lol_hit   = 1'b0;
    case (state)
      RESET_PLL: if (pulse_cnt == PULSE_LAST) nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (timeout)     timed_out = 1'b1;
        else if (lock_s) nxt = QUALIFY;
      end
      QUALIFY: begin
        if (stab_done)    nxt = RUN;
        else if (timeout) timed_out = 1'b1;
        else if (!lock_s) nxt = WAIT_LOCK;
      end
      RUN: if (!lock_s) begin
        nxt       = RESET_PLL;
        retry_clr = 1'b1;
        lol_hit   = 1'b1;
      end
      FAULT: if (retry_req) begin
        nxt       = RESET_PLL;
        retry_clr = 1'b1;
      end
      default: nxt = RESET_PLL;
    endcase
    retry_inc = timed_out && (retry_cnt != RETRY_MAX);
    if (timed_out) nxt = retry_inc ? RESET_PLL : FAULT;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= RESET_PLL;
      sync_pipe <= '0;
      pulse_cnt <= '0;
      to_cnt    <= '0;
      stab_cnt  <= '0;
      retry_cnt <= '0;
      lol_count <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      pll_ok    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= nxt;
      sync_pipe <= {sync_pipe[0], pll_locked};
      pulse_cnt <= (state == RESET_PLL && nxt == RESET_PLL) ? pulse_cnt + PW'(1) : '0;
      // Timeout spans WAIT_LOCK and QUALIFY; only a fresh PLL reset clears it.
      to_cnt    <= ((state == WAIT_LOCK || state == QUALIFY) &&
                    (nxt == WAIT_LOCK || nxt == QUALIFY)) ? to_cnt + TW'(1) : '0;
      stab_cnt  <= (state == QUALIFY && nxt == QUALIFY) ? stab_cnt + SW'(1) : '0;
      if (retry_clr)      retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + RETRY_W'(1);
      if (lol_hit && lol_count != 8'hFF) lol_count <= lol_count + 8'd1;
      pll_rst   <= (nxt == RESET_PLL);
      sys_rst   <= (nxt != RUN);
      pll_ok    <= (nxt == RUN);
      fault     <= (nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: stimulus pushes cycle-tagged expected output snapshots, a negedge
// monitor pops and compares them when that cycle's outputs are presented.
module tb_pll_lock_supervisor;
  localparam int P = 4, T = 64, S = 8, R = 2, RW = 3;

  logic          refclk = 1'b0;
  logic          rst = 1'b1, pll_locked = 1'b0, retry_req = 1'b0;
  logic          pll_rst, sys_rst, pll_ok, fault;
  logic [RW-1:0] retry_cnt;
  logic [7:0]    lol_count;

  int cyc = 0, n_tests = 0, n_fail = 0;

  typedef struct {
    int    c;
    string nm;
    logic  pr, sr, ok, f;
    int    rc, lol;
  } exp_t;
  exp_t exp_q[$];

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(P), .LOCK_TIMEOUT_CYCLES(T), .LOCK_STABLE_CYCLES(S),
    .MAX_RETRIES(R), .RETRY_W(RW)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .retry_req(retry_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .pll_ok(pll_ok), .fault(fault),
    .retry_cnt(retry_cnt), .lol_count(lol_count)
  );

  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input string nm, input logic pr, input logic sr,
                           input logic ok, input logic f, input int rc, input int lol);
    exp_t e;
    e.c = c; e.nm = nm; e.pr = pr; e.sr = sr; e.ok = ok; e.f = f; e.rc = rc; e.lol = lol;
    exp_q.push_back(e);
  endtask

  task automatic check(input exp_t e);
    n_tests++;
    if (e.c != cyc || pll_rst !== e.pr || sys_rst !== e.sr || pll_ok !== e.ok ||
        fault !== e.f || retry_cnt !== RW'(e.rc) || lol_count !== 8'(e.lol)) begin
      n_fail++;
      $display("FAIL %s cyc=%0d(due %0d): got pll_rst=%b sys_rst=%b pll_ok=%b fault=%b retry=%0d lol=%0d, want %b %b %b %b %0d %0d",
               e.nm, cyc, e.c, pll_rst, sys_rst, pll_ok, fault, retry_cnt, lol_count,
               e.pr, e.sr, e.ok, e.f, e.rc, e.lol);
    end
  endtask

  // Monitor: every cycle's outputs are presented at the falling edge.
  initial forever begin
    int i;
    @(negedge refclk);
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].c <= cyc) begin
        check(exp_q[i]);
        exp_q.delete(i);
      end else i++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic do_reset(output int r);
    rst = 1'b1; pll_locked = 1'b0; retry_req = 1'b0;
    expect_at(cyc + 1, "reset_state", 1, 1, 0, 0, 0, 0);
    tick(1);
    rst = 1'b0;
    r = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, f, n, k, f2, f3, lp, ln;

    // Clean lock: 4-cycle PLL reset pulse, RUN 10 edges after the lock sampling edge
    do_reset(r);
    f = r + P;
    expect_at(r + 3, "s1_pulse_hi", 1, 1, 0, 0, 0, 0);
    expect_at(r + 4, "s1_pulse_lo", 0, 1, 0, 0, 0, 0);
    wait_until(f + 10);
    pll_locked = 1'b1;
    n = f + 11;
    expect_at(n + 9,  "s1_pre_run", 0, 1, 0, 0, 0, 0);
    expect_at(n + 10, "s1_run",     0, 0, 1, 0, 0, 0);
    wait_until(n + 11);
    retry_req = 1'b1;
    expect_at(cyc + 1, "run_ignores_retry",  0, 0, 1, 0, 0, 0);
    expect_at(cyc + 2, "run_ignores_retry2", 0, 0, 1, 0, 0, 0);
    tick(1);
    retry_req = 1'b0;
    tick(2);

    // Chatter in QUALIFY: 5 locked samples, 2 low, then steady
    do_reset(r);
    f = r + P;
    wait_until(f + 2);
    pll_locked = 1'b1;
    n = f + 3;
    expect_at(n + 6,  "s2_qualify",  0, 1, 0, 0, 0, 0);
    expect_at(n + 8,  "s2_dropped",  0, 1, 0, 0, 0, 0);
    expect_at(n + 16, "s2_pre_run",  0, 1, 0, 0, 0, 0);
    expect_at(n + 17, "s2_run",      0, 0, 1, 0, 0, 0);
    wait_until(n + 4);
    pll_locked = 1'b0;
    wait_until(n + 6);
    pll_locked = 1'b1;
    wait_until(n + 18);

    // Loss of lock in RUN, repeated until lol_count saturates
    for (int i = 0; i < 256; i++) begin
      k  = cyc;
      n  = k + 1;
      lp = (i > 255) ? 255 : i;
      ln = (i + 1 > 255) ? 255 : i + 1;
      expect_at(n + 1, "lol_pre",  0, 0, 1, 0, 0, lp);
      expect_at(n + 2, "lol_drop", 1, 1, 0, 0, 0, ln);
      if (i == 0) begin
        expect_at(n + 5,  "lol_pulse_hi", 1, 1, 0, 0, 0, ln);
        expect_at(n + 6,  "lol_pulse_lo", 0, 1, 0, 0, 0, ln);
        expect_at(n + 14, "lol_pre_run",  0, 1, 0, 0, 0, ln);
      end
      expect_at(n + 15, "lol_rerun", 0, 0, 1, 0, 0, ln);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(16);
    end

    // Reset mid-QUALIFY clears everything including lol_count
    k = cyc;
    n = k + 1;
    expect_at(n + 9,  "s6_qualify", 0, 1, 0, 0, 0, 255);
    expect_at(n + 10, "s6_reset",   1, 1, 0, 0, 0, 0);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    wait_until(n + 9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expect_at(cyc + 3, "s6_pulse_hi", 1, 1, 0, 0, 0, 0);
    expect_at(cyc + 4, "s6_pulse_lo", 0, 1, 0, 0, 0, 0);
    tick(6);

    // Timeout to FAULT: 3 PLL reset pulses, retries 0->1->2, then FAULT holds
    do_reset(r);
    f  = r + P;
    f2 = f + T + P;
    f3 = f2 + T + P;
    expect_at(f + 63,       "to1_pre",    0, 1, 0, 0, 0, 0);
    expect_at(f + 64,       "to1_retry",  1, 1, 0, 0, 1, 0);
    expect_at(f + 67,       "to1_hi",     1, 1, 0, 0, 1, 0);
    expect_at(f2,           "to1_lo",     0, 1, 0, 0, 1, 0);
    expect_at(f2 + 63,      "to2_pre",    0, 1, 0, 0, 1, 0);
    expect_at(f2 + 64,      "to2_retry",  1, 1, 0, 0, 2, 0);
    expect_at(f3,           "to2_lo",     0, 1, 0, 0, 2, 0);
    expect_at(f3 + 63,      "to3_pre",    0, 1, 0, 0, 2, 0);
    expect_at(f3 + 64,      "to_fault",   0, 1, 0, 1, 2, 0);
    expect_at(f3 + 64 + 200, "fault_hold", 0, 1, 0, 1, 2, 0);
    wait_until(f3 + 64 + 201);

    // Recovery from FAULT
    k = cyc;
    expect_at(k + 1,  "rec_reset",  1, 1, 0, 0, 0, 0);
    expect_at(k + 4,  "rec_hi",     1, 1, 0, 0, 0, 0);
    expect_at(k + 5,  "rec_lo",     0, 1, 0, 0, 0, 0);
    expect_at(k + 15, "rec_prerun", 0, 1, 0, 0, 0, 0);
    expect_at(k + 16, "rec_run",    0, 0, 1, 0, 0, 0);
    retry_req = 1'b1;
    tick(1);
    retry_req = 1'b0;
    wait_until(k + 5);
    pll_locked = 1'b1;
    wait_until(k + 18);

    tick(2);
    while (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked, due cyc %0d, now %0d", exp_q[0].nm, exp_q[0].c, cyc);
      exp_q.delete(0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
